// File: rtl/mux_stim_gen_if.sv
// Handshake and vector bus between the stimulus generator and its consumer
// (the 2-bit/2:1 multiplexer plus a downstream checker).
interface mux_stim_gen_if;
    logic       start;
    logic       pause;
    logic [1:0] data_out;
    logic       sel_out;
    logic       exp_y;
    logic       vec_valid;
    logic       busy;
    logic       done;
    logic [7:0] vec_count;

    modport master (
        input  start, pause,
        output data_out, sel_out, exp_y, vec_valid, busy, done, vec_count
    );

    modport slave (
        output start, pause,
        input  data_out, sel_out, exp_y, vec_valid, busy, done, vec_count
    );
endinterface

// File: rtl/mux_stim_gen.sv
// Clocked, reproducible stimulus source for the 2-bit/2:1 multiplexer.
// An 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) supplies NUM_VECTORS
// {data, select} vectors, each held for STEP_CYCLES unpaused cycles, with the
// expected mux output driven alongside so a checker can compare directly.
module mux_stim_gen #(
    parameter int unsigned NUM_VECTORS = 10,
    parameter int unsigned STEP_CYCLES = 1,
    parameter logic [7:0]  SEED        = 8'hA5
) (
    input logic            clk,
    input logic            rst_n,
    mux_stim_gen_if.master bus
);
    localparam logic [7:0] HOLD_LAST = 8'(STEP_CYCLES - 1);
    localparam logic [7:0] VEC_LAST  = 8'(NUM_VECTORS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] lfsr;
    logic [7:0] lfsr_nxt;
    logic [7:0] hold_cnt;
    logic [7:0] hold_nxt;
    logic [7:0] vec_cnt;
    logic [7:0] vec_cnt_nxt;

    // State, LFSR, hold counter and vector count registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            lfsr     <= SEED;
            hold_cnt <= '0;
            vec_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            lfsr     <= lfsr_nxt;
            hold_cnt <= hold_nxt;
            vec_cnt  <= vec_cnt_nxt;
        end
    end

    // Next-state logic: start a run, step vectors when their hold expires, finish
    always_comb begin
        state_nxt   = state;
        lfsr_nxt    = lfsr;
        hold_nxt    = hold_cnt;
        vec_cnt_nxt = vec_cnt;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt   = RUN;
                    lfsr_nxt    = SEED;
                    hold_nxt    = '0;
                    vec_cnt_nxt = '0;
                end
            end
            RUN: begin
                if (!bus.pause) begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_nxt    = '0;
                        lfsr_nxt    = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                        vec_cnt_nxt = vec_cnt + 8'd1;
                        if (vec_cnt == VEC_LAST) begin
                            state_nxt = DONE;
                        end
                    end else begin
                        hold_nxt = hold_cnt + 8'd1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode: vector fields only live in RUN, pause just drops vec_valid
    always_comb begin
        bus.data_out  = 2'b00;
        bus.sel_out   = 1'b0;
        bus.exp_y     = 1'b0;
        bus.vec_valid = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.vec_count = vec_cnt;
        if (state == RUN) begin
            bus.data_out  = lfsr[1:0];
            bus.sel_out   = lfsr[2];
            bus.exp_y     = lfsr[2] ? lfsr[1] : lfsr[0];
            bus.vec_valid = !bus.pause;
            bus.busy      = 1'b1;
        end else if (state == DONE) begin
            bus.done = 1'b1;
        end
    end
endmodule

// File: tb/tb_mux_stim_gen.sv
// Scoreboard bench for mux_stim_gen: each accepted start pushes the whole
// expected run (one entry per visible cycle plus the done cycle) into a queue;
// a negedge monitor pops an entry on every vec_valid or done cycle.
module tb_mux_stim_gen;
    localparam int         NUM_VECTORS = 3;
    localparam int         STEP_CYCLES = 2;
    localparam logic [7:0] SEED        = 8'hA5;

    typedef struct packed {
        logic [1:0] data;
        logic       sel;
        logic       exp_y;
        logic [7:0] count;
        logic       last;
    } expect_t;

    logic clk = 1'b0;
    logic rst_n;

    mux_stim_gen_if bus ();

    mux_stim_gen #(
        .NUM_VECTORS(NUM_VECTORS),
        .STEP_CYCLES(STEP_CYCLES),
        .SEED       (SEED)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    expect_t    sb_q[$];
    logic [7:0] vec_seq[NUM_VECTORS];
    int         remaining  = 0;
    bit         in_done    = 1'b0;
    logic [7:0] idle_count = 8'd0;
    bit         mon_en     = 1'b0;
    int         checks     = 0;
    int         passes     = 0;

    // Polynomial x^8+x^6+x^5+x^4+1 as a tap mask on bits 7,5,4,3
    function automatic logic [7:0] lfsrStep(input logic [7:0] s);
        return {s[6:0], ^(s & 8'b1011_1000)};
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then advance the run-level reference model at the edge
    task automatic applyStimulus(input logic s, input logic p, input logic r);
        expect_t e;
        logic [7:0] v;
        bus.start = s;
        bus.pause = p;
        rst_n     = r;
        @(posedge clk);
        if (!r) begin
            remaining  = 0;
            in_done    = 1'b0;
            idle_count = 8'd0;
            sb_q.delete();
        end else if (in_done) begin
            in_done    = 1'b0;
            idle_count = 8'(NUM_VECTORS);
        end else if (remaining > 0) begin
            if (!p) begin
                remaining--;
                if (remaining == 0) in_done = 1'b1;
            end
        end else if (s) begin
            remaining = NUM_VECTORS * STEP_CYCLES;
            for (int k = 0; k < NUM_VECTORS; k++) begin
                v = vec_seq[k];
                for (int c = 0; c < STEP_CYCLES; c++) begin
                    e.data  = v[1:0];
                    e.sel   = v[2];
                    e.exp_y = e.data[e.sel];
                    e.count = 8'(k);
                    e.last  = 1'b0;
                    sb_q.push_back(e);
                end
            end
            e.data  = 2'b00;
            e.sel   = 1'b0;
            e.exp_y = 1'b0;
            e.count = 8'(NUM_VECTORS);
            e.last  = 1'b1;
            sb_q.push_back(e);
        end
        #1;
    endtask

    // Monitor: control flags every cycle, pop on each presented vector or done
    initial begin
        expect_t e;
        logic    exp_busy;
        logic    exp_valid;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                exp_busy  = (remaining > 0);
                exp_valid = exp_busy && !bus.pause;
                checkOutput("ctrl", {13'd0, bus.busy, bus.done, bus.vec_valid},
                            {13'd0, exp_busy, in_done, exp_valid});
                if (bus.vec_valid || bus.done) begin
                    if (sb_q.size() == 0) begin
                        checkOutput("sb_depth", 16'(sb_q.size()), 16'd1);
                    end else begin
                        e = sb_q.pop_front();
                        checkOutput("vector",
                            {3'd0, bus.data_out, bus.sel_out, bus.exp_y, bus.vec_count, bus.done},
                            {3'd0, e.data, e.sel, e.exp_y, e.count, e.last});
                    end
                end else if (bus.busy) begin
                    if (sb_q.size() == 0) begin
                        checkOutput("sb_depth", 16'(sb_q.size()), 16'd1);
                    end else begin
                        e = sb_q[0];
                        checkOutput("held",
                            {4'd0, bus.data_out, bus.sel_out, bus.exp_y, bus.vec_count},
                            {4'd0, e.data, e.sel, e.exp_y, e.count});
                    end
                end else begin
                    checkOutput("idle",
                        {4'd0, bus.data_out, bus.sel_out, bus.exp_y, bus.vec_count},
                        {4'd0, 2'b00, 1'b0, 1'b0, idle_count});
                end
            end
        end
    end

    // Directed scenarios followed by randomized start/pause/reset traffic
    initial begin
        logic [7:0] s;
        s = SEED;
        for (int k = 0; k < NUM_VECTORS; k++) begin
            vec_seq[k] = s;
            s = lfsrStep(s);
        end
        bus.start = 1'b0;
        bus.pause = 1'b0;
        rst_n     = 1'b0;

        // Reset held with start high
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            mon_en = 1'b1;
        end
        for (int c = 0; c < 2; c++) applyStimulus(1'b0, 1'b0, 1'b1);

        // Basic run
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int c = 1; c <= 9; c++) applyStimulus(1'b0, 1'b0, 1'b1);

        // Pause during cycles 3-5
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int c = 1; c <= 12; c++) applyStimulus(1'b0, (c >= 3 && c <= 5), 1'b1);

        // Start pulses at cycles 2 and 7 are ignored
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int c = 1; c <= 10; c++) applyStimulus((c == 2 || c == 7), 1'b0, 1'b1);

        // Reset at cycle 4 aborts the run, then a clean replay
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int c = 1; c <= 3; c++) applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int c = 1; c <= 9; c++) applyStimulus(1'b0, 1'b0, 1'b1);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            applyStimulus(($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 60) != 0);
        end

        // Drain any run in flight
        for (int c = 0; c < 20; c++) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("sb_drain", 16'(sb_q.size()), 16'd0);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
